hdlc_rx_monitor: RTL

Synthesizable, parametrised protocol monitor for the HDLC receiver. It watches the serial Rx line and the Rx status/control outputs, and checks four rules in hardware: flag-detect latency, spurious flag detect, abort propagation, and end-of-frame status consistency. Violations are reported as per-rule pulses, sticky bits and a saturating error counter. The block sits beside the Rx module in simulation and on FPGA builds. It adds configurable latencies and error accounting that are usable without a simulator.

---
 rtl/hdlc_rx_monitor.sv | 106 ++++++++++
 1 files changed

// File: rtl/hdlc_rx_monitor.sv
// Protocol monitor for the HDLC receiver: checks flag-detect latency, spurious
// flag detects, abort propagation and end-of-frame status consistency.
module hdlc_rx_monitor #(
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned ABORT_LAT = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic             Clr,
  input  logic             Rx,
  input  logic             Rx_FlagDetect,
  input  logic             Rx_ValidFrame,
  input  logic             Rx_AbortDetect,
  input  logic             Rx_AbortSignal,
  input  logic             Rx_Overflow,
  input  logic             Rx_FrameError,
  input  logic             Rx_Ready,
  input  logic             Rx_EoF,
  output logic [3:0]       ErrPulse,
  output logic [3:0]       ErrVec,
  output logic [CNT_W-1:0] ErrCnt,
  output logic [CNT_W-1:0] FlagCnt
);

  localparam logic [7:0]       FLAG_PAT = 8'b0111_1110;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [7:0]           sh;
  logic [7:0]           shNext;
  logic                 flagMatch;
  logic [FLAG_LAT-1:0]  fpend;
  logic [FLAG_LAT:0]    fpendShift;
  logic [ABORT_LAT-1:0] apend;
  logic [ABORT_LAT:0]   apendShift;
  logic                 eofQ;
  logic                 statusOk;
  logic [3:0]           fired;
  logic [2:0]           firedCnt;
  logic [CNT_W:0]       errSum;
  logic [CNT_W-1:0]     errCntNext;
  logic [CNT_W-1:0]     flagCntNext;

  always_comb begin
    // Match on the post-edge shift value so the flag's final edge launches
    // the pipeline and the check lands exactly FLAG_LAT edges later.
    shNext     = {sh[6:0], Rx};
    flagMatch  = (shNext == FLAG_PAT);
    fpendShift = {fpend, flagMatch & Enable};
    apendShift = {apend, Rx_AbortDetect & Rx_ValidFrame & Enable};

    statusOk = 1'b0;
    if (Rx_AbortSignal)
      statusOk = !Rx_Overflow && !Rx_FrameError && !Rx_Ready;
    else if (Rx_Overflow)
      statusOk = !Rx_FrameError && !Rx_Ready;
    else if (Rx_FrameError)
      statusOk = !Rx_Ready;
    else
      statusOk = Rx_Ready;

    fired    = '0;
    fired[0] = fpend[FLAG_LAT-1] & ~Rx_FlagDetect;
    fired[1] = Rx_FlagDetect & Enable & ~fpend[FLAG_LAT-1];
    fired[2] = apend[ABORT_LAT-1] & ~Rx_AbortSignal;
    fired[3] = Enable & Rx_EoF & ~eofQ & ~statusOk;

    firedCnt = {2'b00, fired[0]} + {2'b00, fired[1]}
             + {2'b00, fired[2]} + {2'b00, fired[3]};
    // One spare bit catches any overshoot past the maximum count.
    errSum      = {1'b0, ErrCnt} + (CNT_W+1)'(firedCnt);
    errCntNext  = errSum[CNT_W] ? CNT_MAX : errSum[CNT_W-1:0];
    flagCntNext = (FlagCnt == CNT_MAX) ? FlagCnt : FlagCnt + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sh       <= 8'hFF;
      fpend    <= '0;
      apend    <= '0;
      eofQ     <= 1'b1;
      ErrPulse <= '0;
      ErrVec   <= '0;
      ErrCnt   <= '0;
      FlagCnt  <= '0;
    end else begin
      sh       <= shNext;
      fpend    <= fpendShift[FLAG_LAT-1:0];
      apend    <= apendShift[ABORT_LAT-1:0];
      eofQ     <= Rx_EoF;
      ErrPulse <= fired;
      if (Clr) begin
        ErrVec  <= '0;
        ErrCnt  <= '0;
        FlagCnt <= '0;
      end else begin
        ErrVec <= ErrVec | fired;
        ErrCnt <= errCntNext;
        if (flagMatch)
          FlagCnt <= flagCntNext;
      end
    end
  end

endmodule
